// File: rtl/cell_sweep_pkg.sv
// Shared mode encodings, FSM state type and helpers for the cell truth-table sweeper.
package cell_sweep_pkg;

    localparam int unsigned MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_NOR  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_NAND = 3'd1;
    localparam logic [MODE_W-1:0] MODE_OR   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_AND  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_XOR  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Encodings above XNOR are reserved and never launch a sweep.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        return (m <= MODE_XNOR);
    endfunction

endpackage

// File: rtl/cell_sweep_checker_ref.sv
// Reference model: expected ZN of an N-input NOR/NAND/OR/AND/XOR/XNOR cell for one input vector.
module cell_ref_model
    import cell_sweep_pkg::*;
#(
    parameter int unsigned N_IN = 3
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [N_IN-1:0]   vec,
    output logic              exp
);

    always_comb begin
        exp = 1'b0;
        case (mode)
            MODE_NOR:  exp = ~(|vec);
            MODE_NAND: exp = ~(&vec);
            MODE_OR:   exp = |vec;
            MODE_AND:  exp = &vec;
            MODE_XOR:  exp = ^vec;
            MODE_XNOR: exp = ~(^vec);
            default:   exp = 1'b0;
        endcase
    end

endmodule

// File: rtl/cell_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of a cell under test,
// compares the settled ZN against the reference model and reports pass, error count and first failure.
module cell_sweep_checker
    import cell_sweep_pkg::*;
#(
    parameter int unsigned N_IN       = 3,
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [MODE_W-1:0]   mode,
    input  logic                dut_zn,
    output logic [N_IN-1:0]     stim,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [N_IN-1:0]     first_fail_vec,
    output logic                first_fail_valid,
    output logic                sample_valid,
    output logic [N_IN-1:0]     sample_vec,
    output logic                sample_zn,
    output logic                sample_exp
);

    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [N_IN-1:0]  STIM_LAST   = '1;
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_t              state, state_d;
    logic [CNT_W-1:0]    settle_q, settle_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [N_IN-1:0]     stim_d;
    logic                busy_d, done_d, pass_d;
    logic [ERR_W-1:0]    err_d;
    logic [N_IN-1:0]     ffvec_d;
    logic                ffv_d;
    logic                sv_d;
    logic [N_IN-1:0]     svec_d;
    logic                szn_d, sexp_d;
    logic                exp_ref;
    logic                mismatch;

    cell_ref_model #(
        .N_IN (N_IN)
    ) u_ref (
        .mode (mode_q),
        .vec  (stim),
        .exp  (exp_ref)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state and next-value logic for every registered output
    always_comb begin
        state_d  = state;
        settle_d = settle_q;
        mode_d   = mode_q;
        stim_d   = stim;
        busy_d   = busy;
        done_d   = 1'b0;
        pass_d   = pass;
        err_d    = err_count;
        ffvec_d  = first_fail_vec;
        ffv_d    = first_fail_valid;
        sv_d     = 1'b0;
        svec_d   = sample_vec;
        szn_d    = sample_zn;
        sexp_d   = sample_exp;
        mismatch = (dut_zn != exp_ref);

        if (abort) begin
            // Abort wins over start and over a pending compare; partial results are kept.
            state_d  = ST_IDLE;
            stim_d   = '0;
            busy_d   = 1'b0;
            settle_d = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stim_d   = '0;
                        err_d    = '0;
                        ffv_d    = 1'b0;
                        pass_d   = 1'b0;
                        settle_d = '0;
                        if (mode_is_legal(mode)) begin
                            mode_d  = mode;
                            busy_d  = 1'b1;
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = ST_SAMPLE;
                    end else begin
                        settle_d = CNT_W'(settle_q + 1'b1);
                    end
                end

                ST_SAMPLE: begin
                    sv_d     = 1'b1;
                    svec_d   = stim;
                    szn_d    = dut_zn;
                    sexp_d   = exp_ref;
                    settle_d = '0;
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_d = ERR_W'(err_count + 1'b1);
                        end
                        if (!first_fail_valid) begin
                            ffv_d   = 1'b1;
                            ffvec_d = stim;
                        end
                    end
                    // stim stops at all-ones so it never rolls back to 0 inside a sweep
                    if (stim == STIM_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d  = N_IN'(stim + 1'b1);
                        state_d = ST_SETTLE;
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Registered datapath, counters and trace outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q         <= '0;
            mode_q           <= MODE_NOR;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            sample_valid     <= 1'b0;
            sample_vec       <= '0;
            sample_zn        <= 1'b0;
            sample_exp       <= 1'b0;
        end else begin
            settle_q         <= settle_d;
            mode_q           <= mode_d;
            stim             <= stim_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail_vec   <= ffvec_d;
            first_fail_valid <= ffv_d;
            sample_valid     <= sv_d;
            sample_vec       <= svec_d;
            sample_zn        <= szn_d;
            sample_exp       <= sexp_d;
        end
    end

endmodule

// File: tb/tb_cell_sweep_checker.sv
// Scoreboard bench for cell_sweep_checker: a 3-input and a 4-input (narrow error counter) instance.
module tb_cell_sweep_checker;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned PER    = SETTLE + 1;
    localparam int unsigned NA     = 3;
    localparam int unsigned NB     = 4;
    localparam int unsigned EWA    = 8;
    localparam int unsigned EWB    = 2;

    typedef struct {
        logic [7:0] vec;
        logic       exp;
        logic       zn;
    } samp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start_a = 1'b0, abort_a = 1'b0, start_b = 1'b0, abort_b = 1'b0;
    logic [2:0]     mode_a = 3'd0, mode_b = 3'd0, cell_mode_a = 3'd0, cell_mode_b = 3'd0;
    logic [1:0]     fault_a = 2'd0, fault_b = 2'd0;
    logic           zn_a, zn_b;

    logic [NA-1:0]  stim_a, ffvec_a, svec_a;
    logic [NB-1:0]  stim_b, ffvec_b, svec_b;
    logic [EWA-1:0] err_a;
    logic [EWB-1:0] err_b;
    logic busy_a, done_a, pass_a, ffv_a, sv_a, szn_a, sexp_a;
    logic busy_b, done_b, pass_b, ffv_b, sv_b, szn_b, sexp_b;

    int n_checks = 0;
    int n_pass   = 0;
    samp_t q_a[$];
    samp_t q_b[$];
    logic  sel = 1'b0;

    function automatic logic tb_ref(input logic [2:0] m, input logic [7:0] v, input int n);
        int ones = 0;
        for (int i = 0; i < n; i++) if (v[i]) ones++;
        case (m)
            3'd0:    return (ones == 0);
            3'd1:    return (ones != n);
            3'd2:    return (ones != 0);
            3'd3:    return (ones == n);
            3'd4:    return ones[0];
            3'd5:    return !ones[0];
            default: return 1'b0;
        endcase
    endfunction

    // Cells under test: golden model, or stuck-at-1 / stuck-at-0 faults
    assign zn_a = (fault_a == 2'd1) ? 1'b1 : (fault_a == 2'd2) ? 1'b0 : tb_ref(cell_mode_a, 8'(stim_a), NA);
    assign zn_b = (fault_b == 2'd1) ? 1'b1 : (fault_b == 2'd2) ? 1'b0 : tb_ref(cell_mode_b, 8'(stim_b), NB);

    cell_sweep_checker #(.N_IN(NA), .SETTLE_CYC(SETTLE), .ERR_W(EWA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .mode(mode_a), .dut_zn(zn_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffvec_a), .first_fail_valid(ffv_a), .sample_valid(sv_a),
        .sample_vec(svec_a), .sample_zn(szn_a), .sample_exp(sexp_a)
    );

    cell_sweep_checker #(.N_IN(NB), .SETTLE_CYC(SETTLE), .ERR_W(EWB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .mode(mode_b), .dut_zn(zn_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffvec_b), .first_fail_valid(ffv_b), .sample_valid(sv_b),
        .sample_vec(svec_b), .sample_zn(szn_b), .sample_exp(sexp_b)
    );

    logic       c_busy, c_done, c_pass, c_ffv, c_zero_a, c_zero_b, c_zero;
    logic [7:0] c_err, c_ffvec, c_stim;
    assign c_busy   = sel ? busy_b : busy_a;
    assign c_done   = sel ? done_b : done_a;
    assign c_pass   = sel ? pass_b : pass_a;
    assign c_ffv    = sel ? ffv_b  : ffv_a;
    assign c_err    = sel ? 8'(err_b)   : err_a;
    assign c_ffvec  = sel ? 8'(ffvec_b) : 8'(ffvec_a);
    assign c_stim   = sel ? 8'(stim_b)  : 8'(stim_a);
    assign c_zero_a = ({stim_a, busy_a, done_a, pass_a, err_a, ffvec_a, ffv_a, sv_a, svec_a, szn_a, sexp_a} == '0);
    assign c_zero_b = ({stim_b, busy_b, done_b, pass_b, err_b, ffvec_b, ffv_b, sv_b, svec_b, szn_b, sexp_b} == '0);
    assign c_zero   = sel ? c_zero_b : c_zero_a;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Scoreboard pop and compare on every sample strobe
    always @(negedge clk) begin
        samp_t e;
        if (rst_n && sv_a) begin
            if (q_a.size() == 0) check_eq("a_unexpected_sample", 32'(sv_a), 32'd0);
            else begin
                e = q_a.pop_front();
                check_eq("a_sample_vec", 32'(svec_a), 32'(e.vec));
                check_eq("a_sample_exp", 32'(sexp_a), 32'(e.exp));
                check_eq("a_sample_zn",  32'(szn_a),  32'(e.zn));
            end
        end
        if (rst_n && sv_b) begin
            if (q_b.size() == 0) check_eq("b_unexpected_sample", 32'(sv_b), 32'd0);
            else begin
                e = q_b.pop_front();
                check_eq("b_sample_vec", 32'(svec_b), 32'(e.vec));
                check_eq("b_sample_exp", 32'(sexp_b), 32'(e.exp));
                check_eq("b_sample_zn",  32'(szn_b),  32'(e.zn));
            end
        end
    end

    task automatic set_in(input logic st, input logic ab, input logic [2:0] m);
        if (sel) begin start_b = st; abort_b = ab; mode_b = m; end
        else     begin start_a = st; abort_a = ab; mode_a = m; end
    endtask

    // One sweep with optional mid-run abort, reset or redundant start (cycle numbers count from start)
    task automatic run_sweep(input int s, input logic [2:0] m, input logic [1:0] flt,
                             input int abort_at, input int reset_at, input int restart_at, input string tag);
        samp_t e;
        int n, nv, emax, cut, mism, err_exp, ffvec_exp, done_cyc, budget;
        logic legal, ffv_exp, done_seen, done_exp;
        sel  = (s != 0);
        n    = sel ? NB : NA;
        nv   = 1 << n;
        emax = sel ? ((1 << EWB) - 1) : ((1 << EWA) - 1);
        cut  = (abort_at > 0) ? abort_at : (reset_at > 0) ? reset_at : 32'h3fff_ffff;
        legal = (m < 3'd6);
        mism = 0; ffv_exp = 1'b0; ffvec_exp = 0;
        if (sel) begin cell_mode_b = m; fault_b = flt; end
        else     begin cell_mode_a = m; fault_a = flt; end
        if (legal) begin
            for (int k = 0; k < nv; k++) begin
                if (PER * (k + 1) + 1 <= cut) begin
                    e.vec = 8'(k);
                    e.exp = tb_ref(m, e.vec, n);
                    e.zn  = (flt == 2'd1) ? 1'b1 : (flt == 2'd2) ? 1'b0 : e.exp;
                    if (sel) q_b.push_back(e); else q_a.push_back(e);
                    if (e.zn != e.exp) begin
                        if (!ffv_exp) begin ffv_exp = 1'b1; ffvec_exp = k; end
                        mism++;
                    end
                end
            end
        end
        err_exp  = (mism > emax) ? emax : mism;
        done_exp = (abort_at == 0) && (reset_at == 0);
        budget   = nv * PER + 10;
        done_seen = 1'b0; done_cyc = 0;

        @(negedge clk); set_in(1'b1, 1'b0, m);
        @(negedge clk); set_in(1'b0, 1'b0, m);
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (cyc == 1) check_eq({tag, "_busy_c1"}, 32'(c_busy), 32'(legal));
            if (c_done && !done_seen) begin
                done_seen = 1'b1; done_cyc = cyc;
                check_eq({tag, "_latency"}, 32'(cyc), legal ? 32'(nv * PER + 1) : 32'd1);
                check_eq({tag, "_pass"}, 32'(c_pass), 32'(legal && (mism == 0)));
                check_eq({tag, "_err"}, 32'(c_err), 32'(err_exp));
                check_eq({tag, "_ffv"}, 32'(c_ffv), 32'(ffv_exp));
                if (ffv_exp) check_eq({tag, "_ffvec"}, 32'(c_ffvec), 32'(ffvec_exp));
                check_eq({tag, "_busy_done"}, 32'(c_busy), 32'd0);
            end
            if (done_seen && cyc == done_cyc + 1) begin
                check_eq({tag, "_done_pulse"}, 32'(c_done), 32'd0);
                break;
            end
            if (abort_at > 0 && cyc == abort_at + 1) begin
                check_eq({tag, "_abort_busy"}, 32'(c_busy), 32'd0);
                check_eq({tag, "_abort_stim"}, 32'(c_stim), 32'd0);
                check_eq({tag, "_abort_err"},  32'(c_err),  32'(err_exp));
                check_eq({tag, "_abort_ffv"},  32'(c_ffv),  32'(ffv_exp));
                if (ffv_exp) check_eq({tag, "_abort_ffvec"}, 32'(c_ffvec), 32'(ffvec_exp));
            end
            if (abort_at > 0 && cyc == abort_at + 6) break;
            set_in(cyc == restart_at, cyc == abort_at, (cyc == restart_at) ? 3'd7 : m);
            if (cyc == reset_at) begin
                #2 rst_n = 1'b0;
                #1 check_eq({tag, "_reset_outs_zero"}, 32'(c_zero), 32'd1);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            @(negedge clk);
        end
        set_in(1'b0, 1'b0, m);
        check_eq({tag, "_done_seen"}, 32'(done_seen), 32'(done_exp));
        @(negedge clk);
        check_eq({tag, "_queue_empty"}, sel ? 32'(q_b.size()) : 32'(q_a.size()), 32'd0);
    endtask

    initial begin
        @(negedge clk);
        sel = 1'b0; #1 check_eq("reset_a_outs_zero", 32'(c_zero), 32'd1);
        sel = 1'b1; #1 check_eq("reset_b_outs_zero", 32'(c_zero), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int m = 0; m < 6; m++) run_sweep(0, 3'(m), 2'd0, 0, 0, 0, $sformatf("a_golden_m%0d", m));
        run_sweep(0, 3'd0, 2'd1, 0, 0, 0, "a_nor_stuck1");
        run_sweep(0, 3'd1, 2'd2, 0, 0, 0, "a_nand_stuck0");
        run_sweep(1, 3'd4, 2'd0, 0, 0, 0, "b_xor_golden");
        run_sweep(1, 3'd5, 2'd0, 0, 0, 0, "b_xnor_golden");
        run_sweep(1, 3'd4, 2'd1, 0, 0, 0, "b_xor_saturate");

        run_sweep(0, 3'd0, 2'd1, 10, 0, 0, "a_abort");
        sel = 1'b0;
        @(negedge clk); set_in(1'b1, 1'b1, 3'd0);
        @(negedge clk); set_in(1'b0, 1'b0, 3'd0);
        check_eq("abort_beats_start_busy", 32'(c_busy), 32'd0);
        repeat (4) @(negedge clk);
        check_eq("abort_beats_start_idle", 32'(c_busy), 32'd0);
        run_sweep(0, 3'd0, 2'd0, 0, 0, 0, "a_after_abort");

        run_sweep(0, 3'd2, 2'd0, 0, 8, 0, "a_reset_mid");
        run_sweep(0, 3'd3, 2'd0, 0, 0, 5, "a_restart_ignored");
        run_sweep(0, 3'd7, 2'd0, 0, 0, 0, "a_reserved7");
        run_sweep(1, 3'd6, 2'd0, 0, 0, 0, "b_reserved6");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
